fnd_stopwatch_counter: RTL and testbench

Generates the 14-bit decimal value (0..9999) shown on the 4-digit FND. It sits directly upstream of the FND display controller, and its `o_counter_data` drives that controller's counter-data input. The block debounces three push-buttons (run/stop, clear, up/down mode), runs a stop/run/clear state machine, and steps a modulo-10000 counter at a fixed tick rate.

---
 rtl/fnd_pkg.sv | 39 +++
 rtl/button_debouncer.sv | 57 +++++
 rtl/fnd_stopwatch_counter.sv | 113 +++++++++++
 tb/tb_fnd_stopwatch_counter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and types for the FND stopwatch path
//
// Purpose: state encoding, count width and count limit shared by the
//          stopwatch counter and the downstream FND display controller.
// Contents:
//   FND_DATA_W     - width of the counter-data bus (14 bits covers 0..9999)
//   FND_MAX_COUNT  - largest displayable count (9999)
//   fnd_state_t    - stopwatch states STOP / RUN / CLEAR
//   fnd_step       - one modulo-10000 step up or down
package fnd_pkg;

    localparam int FND_DATA_W = 14;
    localparam logic [FND_DATA_W-1:0] FND_MAX_COUNT = 14'd9999;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } fnd_state_t;

    // Out-of-range values (>= 9999 going up) fold back to 0 so the counter
    // can never leave 0..9999 even if it were somehow corrupted.
    function automatic logic [FND_DATA_W-1:0] fnd_step(
        input logic [FND_DATA_W-1:0] value,
        input logic                  down
    );
        if (down) begin
            if (value == '0 || value > FND_MAX_COUNT) begin
                return FND_MAX_COUNT;
            end
            return value - FND_DATA_W'(1);
        end
        if (value >= FND_MAX_COUNT) begin
            return '0;
        end
        return value + FND_DATA_W'(1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizer, debouncer and press-edge detector
//
// Purpose: turns a raw asynchronous active-high push-button into a single
//          one-cycle pulse per accepted press.
// Ports:
//   i_clk          in  1  system clock
//   i_reset        in  1  synchronous active-high reset
//   i_btn          in  1  raw asynchronous button level
//   o_press_pulse  out 1  one-cycle pulse on each accepted rising level
// Latency from a stable raw level to the pulse: 2 + DEBOUNCE_CYCLES + 1.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_level;
    logic             accepted;
    logic             accepted_d;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_meta     <= 1'b0;
            sync_level    <= 1'b0;
            accepted      <= 1'b0;
            accepted_d    <= 1'b0;
            stable_cnt    <= '0;
            o_press_pulse <= 1'b0;
        end else begin
            sync_meta     <= i_btn;
            sync_level    <= sync_meta;
            accepted_d    <= accepted;
            o_press_pulse <= accepted & ~accepted_d;

            // The counter only runs while the synchronized level disagrees
            // with the accepted one; any bounce back to the accepted level
            // restarts the stability window.
            if (sync_level == accepted) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                accepted   <= sync_level;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fnd_stopwatch_counter.sv
// rtl/fnd_stopwatch_counter.sv - stop/run/clear stopwatch feeding the FND display
//
// Purpose: debounces three buttons, runs the STOP/RUN/CLEAR state machine and
//          steps a modulo-10000 counter once per prescaler period.
// Ports:
//   i_clk           in  1   system clock (single domain)
//   i_reset         in  1   synchronous active-high reset
//   i_btn_run_stop  in  1   raw button, toggles STOP/RUN
//   i_btn_clear     in  1   raw button, zeroes count and stops
//   i_btn_mode      in  1   raw button, toggles count direction
//   o_counter_data  out 14  current count, 0..9999
//   o_run           out 1   high while in RUN
//   o_mode_down     out 1   0 = count up, 1 = count down
module fnd_stopwatch_counter
    import fnd_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 10,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_btn_run_stop,
    input  logic                  i_btn_clear,
    input  logic                  i_btn_mode,
    output logic [FND_DATA_W-1:0] o_counter_data,
    output logic                  o_run,
    output logic                  o_mode_down
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic             run_stop_pulse;
    logic             clear_pulse;
    logic             mode_pulse;
    logic             tick;
    fnd_state_t       state;
    logic [PRE_W-1:0] prescaler;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run_stop (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_btn         (i_btn_run_stop),
        .o_press_pulse (run_stop_pulse)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_btn         (i_btn_clear),
        .o_press_pulse (clear_pulse)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_btn         (i_btn_mode),
        .o_press_pulse (mode_pulse)
    );

    // The prescaler wraps only while running, so its wrap is the count tick.
    assign tick = (state == RUN) && (prescaler == PRE_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= STOP;
            prescaler      <= '0;
            o_counter_data <= '0;
            o_run          <= 1'b0;
            o_mode_down    <= 1'b0;
        end else begin
            // Direction flips in every state; a tick in this same cycle
            // still uses the register's old value below.
            o_mode_down <= o_mode_down ^ mode_pulse;

            case (state)
                CLEAR: begin
                    state          <= STOP;
                    o_run          <= 1'b0;
                    prescaler      <= '0;
                    o_counter_data <= '0;
                end
                STOP, RUN: begin
                    if (clear_pulse) begin
                        // Clear beats run_stop and swallows a same-cycle tick.
                        state          <= CLEAR;
                        o_run          <= 1'b0;
                        prescaler      <= '0;
                        o_counter_data <= '0;
                    end else begin
                        if (state == RUN) begin
                            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
                            if (tick) begin
                                o_counter_data <= fnd_step(o_counter_data, o_mode_down);
                            end
                        end
                        if (run_stop_pulse) begin
                            state <= (state == RUN) ? STOP : RUN;
                            o_run <= (state != RUN);
                        end
                    end
                end
                default: begin
                    state <= STOP;
                    o_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fnd_stopwatch_counter.sv
// tb/tb_fnd_stopwatch_counter.sv - self-checking bench for fnd_stopwatch_counter
module tb_fnd_stopwatch_counter;

    localparam int DEB = 4;
    localparam int DIV = 10;
    localparam int MOD = 10000;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_btn_run_stop;
    logic        i_btn_clear;
    logic        i_btn_mode;
    logic [13:0] o_counter_data;
    logic        o_run;
    logic        o_mode_down;

    int vectors = 0;
    int miscompares = 0;

    // reference model state: 0 = stop, 1 = run, 2 = clear
    int m_state = 0, m_presc = 0, m_count = 0, m_mode = 0;
    int s1[3], s2[3], prev_d[3], runlen[3], acc[3], rise[3], pulse[3];

    fnd_stopwatch_counter #(
        .CLK_HZ          (100),
        .TICK_HZ         (10),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_btn_run_stop (i_btn_run_stop),
        .i_btn_clear    (i_btn_clear),
        .i_btn_mode     (i_btn_mode),
        .o_counter_data (o_counter_data),
        .o_run          (o_run),
        .o_mode_down    (o_mode_down)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model advanced once per rising edge using the inputs the
    // DUT sampled on that edge. Button i: 0 run_stop, 1 clear, 2 mode.
    task automatic model_edge();
        int r[3];
        int p[3];
        int d;
        r[0] = int'(i_btn_run_stop);
        r[1] = int'(i_btn_clear);
        r[2] = int'(i_btn_mode);
        if (i_reset) begin
            m_state = 0; m_presc = 0; m_count = 0; m_mode = 0;
            for (int b = 0; b < 3; b++) begin
                s1[b] = 0; s2[b] = 0; prev_d[b] = 0; runlen[b] = 0;
                acc[b] = 0; rise[b] = 0; pulse[b] = 0;
            end
            return;
        end
        for (int b = 0; b < 3; b++) p[b] = pulse[b];
        if (m_state == 2) begin
            m_state = 0;
        end else if (p[1] != 0) begin
            m_state = 2; m_count = 0; m_presc = 0;
        end else begin
            if (m_state == 1) begin
                m_presc = (m_presc + 1) % DIV;
                if (m_presc == 0) m_count = (m_count + ((m_mode != 0) ? MOD - 1 : 1)) % MOD;
            end
            if (p[0] != 0) m_state = (m_state == 1) ? 0 : 1;
        end
        if (p[2] != 0) m_mode = 1 - m_mode;
        // Button level is seen two samples late; it is accepted once it has
        // held one value for DEB consecutive samples, and a press shows up as
        // a pulse one cycle after acceptance.
        for (int b = 0; b < 3; b++) begin
            d = s2[b];
            s2[b] = s1[b];
            s1[b] = r[b];
            runlen[b] = (d == prev_d[b]) ? ((runlen[b] < DEB) ? runlen[b] + 1 : runlen[b]) : 1;
            prev_d[b] = d;
            pulse[b] = rise[b];
            rise[b] = 0;
            if (runlen[b] >= DEB && d != acc[b]) begin
                acc[b] = d;
                rise[b] = d;
            end
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
        check("count", int'(o_counter_data), m_count);
        check("run", int'(o_run), int'(m_state == 1));
        check("mode", int'(o_mode_down), m_mode);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_raw(input int b, input logic v);
        case (b)
            0: i_btn_run_stop = v;
            1: i_btn_clear = v;
            default: i_btn_mode = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_raw(b, 1'b1);
        idle(hold);
        set_raw(b, 1'b0);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        cycle();
        i_reset = 1'b0;
    endtask

    task automatic wait_count(input int v, input int budget, input string tag);
        int n = 0;
        while (int'(o_counter_data) != v && n < budget) begin
            cycle();
            n++;
        end
        check(tag, int'(o_counter_data), v);
    endtask

    task automatic wait_change(input int budget, output int v);
        int old = int'(o_counter_data);
        int n = 0;
        while (int'(o_counter_data) == old && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check("change_timeout", n, -1);
        v = int'(o_counter_data);
    endtask

    task automatic wait_run(input int budget);
        int n = 0;
        while (!o_run && n < budget) begin
            cycle();
            n++;
        end
        check("run_rise", int'(o_run), 1);
    endtask

    initial begin
        int v;
        int n;
        int t;
        int hold[3];

        i_reset = 1'b1;
        i_btn_run_stop = 1'b0;
        i_btn_clear = 1'b0;
        i_btn_mode = 1'b0;
        idle(3);
        i_reset = 1'b0;
        check("rst_count", int'(o_counter_data), 0);
        check("rst_run", int'(o_run), 0);
        check("rst_mode", int'(o_mode_down), 0);

        // run press held 8 cycles, then 50 cycles of counting
        press(0, 8);
        check("run_in_8", int'(o_run), 1);
        idle(50);
        check("count_after_50", int'(o_counter_data), 5);
        idle(20);
        check("count_after_70", int'(o_counter_data), 7);

        // wraps: down from 0, then switch to up across 9999
        do_reset();
        press(2, 6);
        idle(4);
        press(0, 6);
        wait_change(40, v);
        check("wrap_down_9999", v, 9999);
        wait_change(40, v);
        check("down_9998", v, 9998);
        press(2, 6);
        wait_change(40, v);
        check("up_9999", v, 9999);
        wait_change(40, v);
        check("wrap_up_0", v, 0);

        // pause at prescaler midpoint, resume continues the tick period
        do_reset();
        press(0, 6);
        wait_count(2, 60, "pause_reach_2");
        idle(7);
        press(0, 6);
        idle(100);
        check("paused_count", int'(o_counter_data), 3);
        check("paused_run", int'(o_run), 0);
        set_raw(0, 1'b1);
        wait_run(20);
        set_raw(0, 1'b0);
        n = 0;
        while (int'(o_counter_data) == 3 && n < 30) begin
            cycle();
            n++;
        end
        check("resume_latency", n, 5);

        // simultaneous clear and run_stop in RUN at count 7
        do_reset();
        press(0, 6);
        wait_count(7, 120, "sim_reach_7");
        set_raw(0, 1'b1);
        set_raw(1, 1'b1);
        idle(6);
        set_raw(0, 1'b0);
        set_raw(1, 1'b0);
        idle(10);
        check("sim_count", int'(o_counter_data), 0);
        check("sim_run", int'(o_run), 0);
        idle(20);
        check("sim_hold", int'(o_counter_data), 0);

        // bouncing clear, then held high; a later run must not be cleared
        do_reset();
        press(0, 6);
        wait_count(2, 60, "bnc_reach_2");
        t = 0;
        while (t < 30) begin
            n = $urandom_range(1, 3);
            set_raw(1, 1'b1);
            idle(n);
            t += n;
            n = $urandom_range(1, 3);
            set_raw(1, 1'b0);
            idle(n);
            t += n;
        end
        set_raw(1, 1'b1);
        idle(40);
        check("bnc_count", int'(o_counter_data), 0);
        check("bnc_run", int'(o_run), 0);
        press(0, 6);
        idle(154);
        set_raw(1, 1'b0);
        check("bnc_single", int'(o_run), 1);

        // reset mid-run in down mode at count 42
        do_reset();
        press(0, 6);
        wait_count(43, 500, "rst_reach_43");
        press(2, 6);
        wait_count(42, 30, "rst_reach_42");
        check("rst_pre_mode", int'(o_mode_down), 1);
        do_reset();
        check("mid_rst_count", int'(o_counter_data), 0);
        check("mid_rst_run", int'(o_run), 0);
        check("mid_rst_mode", int'(o_mode_down), 0);
        set_raw(0, 1'b1);
        wait_run(20);
        set_raw(0, 1'b0);
        n = 0;
        while (int'(o_counter_data) == 0 && n < 30) begin
            cycle();
            n++;
        end
        check("first_tick", n, DIV);

        // randomized button activity with rare resets
        for (int b = 0; b < 3; b++) hold[b] = $urandom_range(1, 12);
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    case (b)
                        0: i_btn_run_stop = ~i_btn_run_stop;
                        1: i_btn_clear = ~i_btn_clear;
                        default: i_btn_mode = ~i_btn_mode;
                    endcase
                    hold[b] = (b == 1 && !i_btn_clear) ? $urandom_range(1, 60) : $urandom_range(1, 12);
                end else begin
                    hold[b]--;
                end
            end
            i_reset = ($urandom_range(0, 799) == 0);
            cycle();
        end
        i_reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
